dmem_arbiter: RTL and testbench

- Arbitrates single-port data memory (SRAM) access between two requesters: port 0 is the LSU, port 1 is the debug/loader port.
- Uses a valid/ready request handshake per port and registers the memory command for one access cycle.
- Returns read data or a write acknowledge as a one-cycle response pulse.
- Sits between the MA-stage LSU/debug logic and the dmem array. It owns the dmem write-enable, read-enable and buffer-enable strobes.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arb_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state, funct3 and command types for the dmem arbiter
package dmem_pkg;

  // Arbiter sequencing: accept in IDLE, drive dmem in ACCESS, pulse response in RESP
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Command captured on accept and replayed to dmem during ACCESS
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        owner;
    logic        err;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and dmem signal bundle for the dmem arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_p0_valid;
  logic              i_p1_valid;
  logic              o_p0_ready;
  logic              o_p1_ready;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [ADDR_W-1:0] i_p1_addr;
  logic              i_p0_we;
  logic              i_p1_we;
  logic [31:0]       i_p0_wdata;
  logic [31:0]       i_p1_wdata;
  logic [2:0]        i_p0_funct3;
  logic [2:0]        i_p1_funct3;
  logic              o_p0_rsp_valid;
  logic              o_p1_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic [31:0]       o_mem_addr;
  logic              o_mem_wren;
  logic              o_mem_rden;
  logic              o_mem_en;
  logic [31:0]       o_mem_wdata;
  logic [2:0]        o_mem_funct3;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_p0_valid, i_p1_valid, i_p0_addr, i_p1_addr, i_p0_we, i_p1_we,
    input  i_p0_wdata, i_p1_wdata, i_p0_funct3, i_p1_funct3, i_mem_rdata,
    output o_p0_ready, o_p1_ready, o_p0_rsp_valid, o_p1_rsp_valid,
    output o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wren, o_mem_rden,
    output o_mem_en, o_mem_wdata, o_mem_funct3
  );

  modport master (
    output i_p0_valid, i_p1_valid, i_p0_addr, i_p1_addr, i_p0_we, i_p1_we,
    output i_p0_wdata, i_p1_wdata, i_p0_funct3, i_p1_funct3, i_mem_rdata,
    input  o_p0_ready, o_p1_ready, o_p0_rsp_valid, o_p1_rsp_valid,
    input  o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wren, o_mem_rden,
    input  o_mem_en, o_mem_wdata, o_mem_funct3
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way winner select; on a tie the port not granted last wins
module dmem_arb_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_winner
);

  // A lone requester always wins; a tie goes to the opposite of the last grant
  always_comb begin
    o_any    = i_valid0 | i_valid1;
    o_winner = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_winner = ~i_last_grant;
    end else if (i_valid1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port dmem arbiter, 3-cycle access; DMEM_ARB_RR_EN enables round-robin ties
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int ADDR_W    = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);

  state_e      state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d;

  logic              win_any;
  logic              win_port;
  logic              last_grant;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  // Pretending port 1 was granted last makes port 0 win every tie
  assign last_grant = 1'b1;
`endif

  dmem_arb_pick u_pick (
    .i_valid0     (bus.i_p0_valid),
    .i_valid1     (bus.i_p1_valid),
    .i_last_grant (last_grant),
    .o_any        (win_any),
    .o_winner     (win_port)
  );

  // Ready only in IDLE for the winner; held low while reset is asserted
  always_comb begin
    bus.o_p0_ready = i_rst_n && (state_q == IDLE) && win_any && !win_port;
    bus.o_p1_ready = i_rst_n && (state_q == IDLE) && win_any &&  win_port;
    accept         = bus.o_p0_ready || bus.o_p1_ready;
    sel_addr       = win_port ? bus.i_p1_addr : bus.i_p0_addr;
  end

  // Next state, command capture on accept, read-data capture at the end of ACCESS
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ACCESS;
          cmd_d.addr   = 32'(sel_addr);
          cmd_d.we     = win_port ? bus.i_p1_we     : bus.i_p0_we;
          cmd_d.wdata  = win_port ? bus.i_p1_wdata  : bus.i_p0_wdata;
          cmd_d.funct3 = win_port ? bus.i_p1_funct3 : bus.i_p0_funct3;
          cmd_d.owner  = win_port;
          cmd_d.err    = ({1'b0, sel_addr} >= ADDR_LIMIT);
`ifdef DMEM_ARB_RR_EN
          last_grant_d = win_port;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (cmd_q.we || cmd_q.err) ? 32'd0 : bus.i_mem_rdata;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset drops any in-flight access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last-grant pointer starts at port 1 so port 0 wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Strobes only in ACCESS for in-range commands; address/data hold between accesses
  always_comb begin
    bus.o_mem_en       = (state_q == ACCESS) && !cmd_q.err;
    bus.o_mem_wren     = bus.o_mem_en &&  cmd_q.we;
    bus.o_mem_rden     = bus.o_mem_en && !cmd_q.we;
    bus.o_mem_addr     = cmd_q.addr;
    bus.o_mem_wdata    = cmd_q.wdata;
    bus.o_mem_funct3   = cmd_q.funct3;
    bus.o_p0_rsp_valid = (state_q == RESP) && !cmd_q.owner;
    bus.o_p1_rsp_valid = (state_q == RESP) &&  cmd_q.owner;
    bus.o_rsp_rdata    = rdata_q;
    bus.o_rsp_err      = cmd_q.err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter against a cycle-count reference model
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MEM_WORDS = 2048;
  localparam int BYTES     = MEM_WORDS * 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        we;
    int          owner;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem[0] is the dmem the DUT drives; mem[1] is the reference copy updated at accept
  logic [7:0] mem [2][BYTES];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld(input int w, input logic [31:0] a, input logic [2:0] f3);
    int i;
    logic [7:0] b0, b1, b2, b3;
    i  = int'(a % BYTES);
    b0 = mem[w][i];
    b1 = mem[w][(i + 1) % BYTES];
    b2 = mem[w][(i + 2) % BYTES];
    b3 = mem[w][(i + 3) % BYTES];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd4:    return {24'd0, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd5:    return {16'd0, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void st(input int w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int i;
    i = int'(a % BYTES);
    case (f3)
      3'd0: mem[w][i] = d[7:0];
      3'd1: begin mem[w][i] = d[7:0]; mem[w][(i + 1) % BYTES] = d[15:8]; end
      3'd2: begin
        mem[w][i] = d[7:0];
        mem[w][(i + 1) % BYTES] = d[15:8];
        mem[w][(i + 2) % BYTES] = d[23:16];
        mem[w][(i + 3) % BYTES] = d[31:24];
      end
      default: ;
    endcase
  endfunction

  // dmem: writes while wren is high, read data presented mid-ACCESS, garbage when not reading
  always @(negedge clk) begin
    if (rst_n && bus.o_mem_wren) st(0, bus.o_mem_addr, bus.o_mem_funct3, bus.o_mem_wdata);
    if (bus.o_mem_rden) bus.i_mem_rdata = ld(0, bus.o_mem_addr, bus.o_mem_funct3);
    else                bus.i_mem_rdata = $urandom;
  end

  // Reference model state
  int          cyc = 0;
  int          next_free = 0;
  int          acc_cyc = 0;
  bit          infl = 0;
  exp_t        ic;
  logic        last_g = 1'b1;
  logic [31:0] lc_addr = '0, lc_wdata = '0;
  logic [2:0]  lc_f3 = '0;
  int          took_cnt [2] = '{0, 0};

  // Observations of the DUT used by the directed literal checks
  logic [31:0] obs_rdata [2];
  logic        obs_err [2];
  int          obs_rsp_cyc [2] = '{0, 0};
  int          obs_acc_cyc [2] = '{0, 0};
  int          acc_cnt [2] = '{0, 0};
  int          rsp_cnt [2] = '{0, 0};
  int          wren_cnt = 0;
  int          en_cnt = 0;
  int          acc_log0 [$];

  // Compare process: expected outputs derived from accept time plus fixed 1/2-cycle offsets
  always @(negedge clk) begin
    logic [1:0] v, e_r;
    int         win;
    bit         e_acc, e_rsp;
    if (!rst_n) begin
      infl      = 0;
      next_free = 0;
      last_g    = 1'b1;
      lc_addr   = '0;
      lc_wdata  = '0;
      lc_f3     = '0;
    end else begin
      v   = {bus.i_p1_valid, bus.i_p0_valid};
      e_r = 2'b00;
      win = 0;
      if (cyc >= next_free && v != 2'b00) begin
        if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
          win = last_g ? 0 : 1;
`else
          win = 0;
`endif
        end else begin
          win = v[1] ? 1 : 0;
        end
        e_r[win] = 1'b1;
      end
      e_acc = infl && (cyc == acc_cyc + 1);
      e_rsp = infl && (cyc == acc_cyc + 2);

      chk("p0_ready", bus.o_p0_ready, e_r[0]);
      chk("p1_ready", bus.o_p1_ready, e_r[1]);
      chk("mem_en",   bus.o_mem_en,   e_acc && !ic.err);
      chk("mem_wren", bus.o_mem_wren, e_acc && !ic.err && ic.we);
      chk("mem_rden", bus.o_mem_rden, e_acc && !ic.err && !ic.we);
      chk("mem_addr", bus.o_mem_addr, lc_addr);
      chk("mem_wdata", bus.o_mem_wdata, lc_wdata);
      chk("mem_funct3", bus.o_mem_funct3, lc_f3);
      chk("p0_rsp_valid", bus.o_p0_rsp_valid, e_rsp && ic.owner == 0);
      chk("p1_rsp_valid", bus.o_p1_rsp_valid, e_rsp && ic.owner == 1);
      if (e_rsp) begin
        chk("rsp_rdata", bus.o_rsp_rdata, ic.rdata);
        chk("rsp_err", bus.o_rsp_err, ic.err);
        infl = 0;
      end

      if (bus.o_mem_wren) wren_cnt++;
      if (bus.o_mem_en) en_cnt++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? bus.o_p0_rsp_valid : bus.o_p1_rsp_valid) begin
          obs_rdata[p]   = bus.o_rsp_rdata;
          obs_err[p]     = bus.o_rsp_err;
          obs_rsp_cyc[p] = cyc;
          rsp_cnt[p]++;
        end
      end
      if (bus.o_p0_ready && v[0]) begin obs_acc_cyc[0] = cyc; acc_cnt[0]++; acc_log0.push_back(cyc); end
      if (bus.o_p1_ready && v[1]) begin obs_acc_cyc[1] = cyc; acc_cnt[1]++; end

      if (e_r[win] && v[win]) begin
        ic.owner = win;
        ic.addr  = win ? bus.i_p1_addr   : bus.i_p0_addr;
        ic.we    = win ? bus.i_p1_we     : bus.i_p0_we;
        ic.wdata = win ? bus.i_p1_wdata  : bus.i_p0_wdata;
        ic.f3    = win ? bus.i_p1_funct3 : bus.i_p0_funct3;
        ic.err   = (ic.addr >= 32'(BYTES));
        ic.rdata = (ic.err || ic.we) ? 32'd0 : ld(1, ic.addr, ic.f3);
        if (ic.we && !ic.err) st(1, ic.addr, ic.f3, ic.wdata);
        infl      = 1;
        acc_cyc   = cyc;
        next_free = cyc + 3;
        last_g    = logic'(win);
        lc_addr   = ic.addr;
        lc_wdata  = ic.wdata;
        lc_f3     = ic.f3;
        took_cnt[win]++;
      end
    end
    cyc++;
  end

  // Requester side: per-port queues, payload held until the model reports the accept
  req_t q0 [$];
  req_t q1 [$];
  req_t cur [2];
  bit   vld [2] = '{0, 0};
  int   seen_cnt [2] = '{0, 0};
  bit   just_taken [2] = '{0, 0};

  task automatic drive();
    bus.i_p0_valid  = vld[0];
    bus.i_p0_we     = cur[0].we;
    bus.i_p0_addr   = cur[0].addr;
    bus.i_p0_wdata  = cur[0].wdata;
    bus.i_p0_funct3 = cur[0].f3;
    bus.i_p1_valid  = vld[1];
    bus.i_p1_we     = cur[1].we;
    bus.i_p1_addr   = cur[1].addr;
    bus.i_p1_wdata  = cur[1].wdata;
    bus.i_p1_funct3 = cur[1].f3;
  endtask

  task automatic service();
    for (int p = 0; p < 2; p++) begin
      just_taken[p] = 0;
      if (vld[p] && took_cnt[p] != seen_cnt[p]) begin
        seen_cnt[p]   = took_cnt[p];
        vld[p]        = 0;
        just_taken[p] = 1;
      end
      if (!vld[p]) begin
        if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1; end
        if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1; end
      end
    end
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    service();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 || vld[0] || vld[1] || infl) begin
      if (n >= budget) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got busy want idle after %0d cycles", budget);
        return;
      end
      step();
      n++;
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.f3 = f3; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int k;
    r.we    = 1'($urandom % 2);
    r.wdata = $urandom;
    r.f3    = 3'($urandom % 8);
    k       = $urandom % 16;
    if (k == 0)      r.addr = 32'h2000 + 32'($urandom % 64) * 4;
    else if (k == 1) r.addr = $urandom | 32'h8000_0000;
    else if (k == 2) r.addr = 32'h1FFC + 32'($urandom % 4);
    else             r.addr = 32'($urandom % BYTES);
    if (r.f3 == 3'd1 || r.f3 == 3'd5) r.addr[0] = 1'b0;
    if (r.f3 == 3'd2) r.addr[1:0] = 2'b00;
    return r;
  endfunction

  initial begin
    int en_before, rsp_before, i0, a0, r0, n;
    rst_n = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = mem[0][i];
    end
    cur[0] = mk(1'b0, 32'd0, 3'd0, 32'd0);
    cur[1] = cur[0];

    // Reset values, with port 0 already requesting
    q0.push_back(mk(1'b1, 32'h10, F3_SW, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 32'h10, F3_LW, 32'h0));
    service();
    #1;
    chk("rst_p0_ready", bus.o_p0_ready, 1'b0);
    chk("rst_p1_ready", bus.o_p1_ready, 1'b0);
    chk("rst_p0_rsp", bus.o_p0_rsp_valid, 1'b0);
    chk("rst_p1_rsp", bus.o_p1_rsp_valid, 1'b0);
    chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
    chk("rst_err", bus.o_rsp_err, 1'b0);
    chk("rst_en", {bus.o_mem_en, bus.o_mem_wren, bus.o_mem_rden}, 3'b000);
    chk("rst_addr", bus.o_mem_addr, 32'd0);
    chk("rst_wdata", bus.o_mem_wdata, 32'd0);
    chk("rst_funct3", bus.o_mem_funct3, 3'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: SW then LW to 0x10
    drain(40);
    chk("t1_wren_pulses", wren_cnt, 1);
    chk("t1_lw_rdata", obs_rdata[0], 32'hDEADBEEF);
    chk("t1_lw_err", obs_err[0], 1'b0);
    chk("t1_latency", obs_rsp_cyc[0] - obs_acc_cyc[0], 2);

    // 2: simultaneous requests
    q0.push_back(mk(1'b0, 32'h0, F3_LW, 32'h0));
    q1.push_back(mk(1'b0, 32'h4, F3_LW, 32'h0));
    drain(40);
`ifdef DMEM_ARB_RR_EN
    chk("t2_rr_order", obs_acc_cyc[0] - obs_acc_cyc[1], 3);
`else
    chk("t2_fixed_order", obs_acc_cyc[1] - obs_acc_cyc[0], 3);
`endif

    // 3: byte store and sign/zero-extending byte loads
    q0.push_back(mk(1'b1, 32'h4, F3_SW, 32'h0));
    drain(40);
    q1.push_back(mk(1'b1, 32'h7, F3_SB, 32'h123456AB));
    drain(40);
    q1.push_back(mk(1'b0, 32'h7, F3_LBU, 32'h0));
    drain(40);
    chk("t3_lbu", obs_rdata[1], 32'h000000AB);
    q1.push_back(mk(1'b0, 32'h7, F3_LB, 32'h0));
    drain(40);
    chk("t3_lb", obs_rdata[1], 32'hFFFFFFAB);

    // 4: range boundary
    en_before = en_cnt;
    q0.push_back(mk(1'b0, 32'h2000, F3_LW, 32'h0));
    drain(40);
    chk("t4_oor_no_strobe", en_cnt - en_before, 0);
    chk("t4_oor_err", obs_err[0], 1'b1);
    chk("t4_oor_rdata", obs_rdata[0], 32'd0);
    q0.push_back(mk(1'b0, 32'h1FFC, F3_LW, 32'h0));
    drain(40);
    chk("t4_last_word_err", obs_err[0], 1'b0);
    q0.push_back(mk(1'b0, 32'h1FFF, F3_LBU, 32'h0));
    drain(40);
    chk("t4_last_byte_err", obs_err[0], 1'b0);

    // 5: reset during ACCESS of a load
    q0.push_back(mk(1'b0, 32'h10, F3_LW, 32'h0));
    n = 0;
    step();
    while (!just_taken[0] && n < 20) begin
      step();
      n++;
    end
    chk("t5_reached_access", just_taken[0], 1'b1);
    chk("t5_en_in_access", bus.o_mem_en, 1'b1);
    chk("t5_addr_in_access", bus.o_mem_addr, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("t5_strobes_drop", {bus.o_mem_en, bus.o_mem_wren, bus.o_mem_rden}, 3'b000);
    chk("t5_addr_reset", bus.o_mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rsp_before = rsp_cnt[0] + rsp_cnt[1];
    repeat (4) step();
    chk("t5_no_rsp", rsp_cnt[0] + rsp_cnt[1], rsp_before);
    q0.push_back(mk(1'b0, 32'h10, F3_LW, 32'h0));
    drain(40);
    chk("t5_after_rst_rdata", obs_rdata[0], 32'hDEADBEEF);

    // 6: back-to-back loads with valid held high
    i0 = acc_log0.size();
    a0 = acc_cnt[0];
    r0 = rsp_cnt[0];
    for (int k = 0; k < 6; k++) q0.push_back(mk(1'b0, 32'($urandom % BYTES) & 32'hFFFF_FFFC, F3_LW, 32'h0));
    drain(80);
    chk("t6_accepts", acc_cnt[0] - a0, 6);
    chk("t6_responses", rsp_cnt[0] - r0, 6);
    for (int k = i0 + 1; k < acc_log0.size(); k++) chk("t6_gap", acc_log0[k] - acc_log0[k - 1], 3);

    // Random traffic on both ports
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() == 0 && ($urandom % 3) == 0) q0.push_back(rnd_req());
      if (q1.size() == 0 && ($urandom % 3) == 0) q1.push_back(rnd_req());
      step();
    end
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
